// File: rtl/brick_pkg.sv
// Shared playfield definitions: geometry, ball direction codes, game-state encodings.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package brick_pkg;

    localparam int          ROWS       = 12;
    localparam int          COLS       = 16;
    localparam int          CELLS      = ROWS * COLS;
    localparam logic [3:0]  PADDLE_ROW = 4'd11;
    // Highest row that may hold a brick; the paddle row sits below it.
    localparam logic [4:0]  LAST_BRICK_ROW = 5'd10;

    // Ball direction as produced by the stepper. RIGHT moves toward column 0.
    typedef enum logic [1:0] {
        UP_RIGHT   = 2'b00,
        UP_LEFT    = 2'b01,
        DOWN_RIGHT = 2'b10,
        DOWN_LEFT  = 2'b11
    } dir_t;

    // Externally visible game state.
    typedef enum logic [1:0] {
        GS_IDLE = 2'd0,
        GS_PLAY = 2'd1,
        GS_WIN  = 2'd2,
        GS_LOSE = 2'd3
    } game_state_t;

    // Internal controller state; SERVE is reported as PLAY.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAY,
        ST_SERVE,
        ST_WIN,
        ST_LOSE
    } ctrl_state_t;

    // Flat bit position of a cell in the occupancy map (row*16 + col).
    function automatic logic [7:0] cell_index(input logic [3:0] row, input logic [3:0] col);
        return {row, col};
    endfunction

    // Freshly loaded brick field: rows top..top+nrows-1 fully populated.
    function automatic logic [CELLS-1:0] brick_map(input int top, input int nrows);
        logic [CELLS-1:0] m;
        m = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (r >= top && r < top + nrows) begin
                    m[r*COLS + c] = 1'b1;
                end
            end
        end
        return m;
    endfunction

    // Paddle cells in the paddle row starting at column pos.
    function automatic logic [CELLS-1:0] paddle_mask(input logic [3:0] pos, input int width);
        logic [CELLS-1:0] m;
        m = '0;
        for (int c = 0; c < COLS; c++) begin
            if (c >= int'(pos) && c < int'(pos) + width) begin
                m[int'(PADDLE_ROW)*COLS + c] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/brick_field_ctrl_hit_resolver.sv
// Finds which bricks around the ball are struck this step and how many.
// Latency: purely combinational, same-cycle result.
// Backpressure: none; evaluated every cycle.
module hit_resolver
    import brick_pkg::*;
(
    input  logic [3:0]       i_ball_row,
    input  logic [3:0]       i_ball_col,
    input  logic [1:0]       i_ball_dir,
    input  logic [CELLS-1:0] i_bricks,
    output logic [CELLS-1:0] o_clear_mask,
    output logic [1:0]       o_clear_cnt
);

    logic       w_up;
    logic       w_right;
    logic [4:0] w_v_row;
    logic [4:0] w_h_col;
    logic       w_row_ok;
    logic       w_v_ok;
    logic       w_h_ok;
    logic [7:0] w_v_idx;
    logic [7:0] w_h_idx;
    logic [7:0] w_d_idx;
    logic       w_v_hit;
    logic       w_h_hit;
    logic       w_d_hit;

    assign w_up    = ~i_ball_dir[1];
    assign w_right = ~i_ball_dir[0];

    // Neighbour coordinates computed one bit wider so that stepping off
    // row 0 / col 0 lands far out of range instead of wrapping to 15.
    assign w_v_row = w_up    ? ({1'b0, i_ball_row} - 5'd1) : ({1'b0, i_ball_row} + 5'd1);
    assign w_h_col = w_right ? ({1'b0, i_ball_col} - 5'd1) : ({1'b0, i_ball_col} + 5'd1);

    // Only rows 0..10 can hold bricks, which also keeps the paddle row untouchable.
    assign w_row_ok = ({1'b0, i_ball_row} <= LAST_BRICK_ROW);
    assign w_v_ok   = (w_v_row <= LAST_BRICK_ROW);
    assign w_h_ok   = (w_h_col <= 5'd15);

    assign w_v_idx = cell_index(w_v_row[3:0], i_ball_col);
    assign w_h_idx = cell_index(i_ball_row,   w_h_col[3:0]);
    assign w_d_idx = cell_index(w_v_row[3:0], w_h_col[3:0]);

    // Diagonal only counts as a hit when both edge neighbours are empty,
    // matching the stepper's bounce priority.
    assign w_v_hit = w_v_ok && i_bricks[w_v_idx];
    assign w_h_hit = w_row_ok && w_h_ok && i_bricks[w_h_idx];
    assign w_d_hit = w_v_ok && w_h_ok && !w_v_hit && !w_h_hit && i_bricks[w_d_idx];

    // Build the one-hot-per-hit clear mask and the clear count.
    always_comb begin
        o_clear_mask = '0;
        if (w_v_hit) o_clear_mask[w_v_idx] = 1'b1;
        if (w_h_hit) o_clear_mask[w_h_idx] = 1'b1;
        if (w_d_hit) o_clear_mask[w_d_idx] = 1'b1;
        o_clear_cnt = {1'b0, w_v_hit} + {1'b0, w_h_hit} + {1'b0, w_d_hit};
    end

endmodule

// File: rtl/brick_field_ctrl.sv
// Breakout game-state stage: owns the brick/paddle map, score, lives and the ball respawn control.
// Latency: one clock; every output is registered and reflects the edge's decisions on the next cycle.
// Backpressure: none; one ball step is consumed on every clock edge.
module brick_field_ctrl
    import brick_pkg::*;
#(
    parameter int BRICK_TOP  = 1,   // first brick row
    parameter int BRICK_ROWS = 3,   // BRICK_TOP+BRICK_ROWS must not exceed 9
    parameter int PADDLE_W   = 4,   // 2..8
    parameter int LIVES      = 3    // 1..3
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              paddle_inc,
    input  logic              paddle_dec,
    input  logic [3:0]        ball_row,
    input  logic [3:0]        ball_col,
    input  logic [1:0]        ball_dir,
    output logic [CELLS-1:0]  data,
    output logic              ball_rst_n,
    output logic [7:0]        score,
    output logic [7:0]        bricks_left,
    output logic [1:0]        lives,
    output logic [1:0]        game_state
);

    localparam logic [CELLS-1:0] BRICK_INIT  = brick_map(BRICK_TOP, BRICK_ROWS);
    localparam logic [3:0]       PAD_MAX     = 4'(16 - PADDLE_W);
    localparam logic [3:0]       PAD_INIT    = 4'((16 - PADDLE_W) / 2);
    localparam logic [7:0]       BRICKS_INIT = 8'(16 * BRICK_ROWS);
    localparam logic [1:0]       LIVES_INIT  = 2'(LIVES);
    localparam logic [CELLS-1:0] DATA_INIT   = BRICK_INIT | paddle_mask(PAD_INIT, PADDLE_W);

    ctrl_state_t      r_state;
    logic [CELLS-1:0] r_bricks;
    logic [3:0]       r_paddle_pos;
    logic [7:0]       r_score;
    logic [7:0]       r_bricks_left;
    logic [1:0]       r_lives;
    logic             r_ball_rst_n;
    logic [CELLS-1:0] r_data;
    game_state_t      r_game_state;

    ctrl_state_t      w_state_nxt;
    logic [CELLS-1:0] w_bricks_nxt;
    logic [3:0]       w_paddle_pos_nxt;
    logic [7:0]       w_score_nxt;
    logic [7:0]       w_bricks_left_nxt;
    logic [1:0]       w_lives_nxt;
    logic             w_ball_rst_n_nxt;
    logic [CELLS-1:0] w_data_nxt;
    game_state_t      w_game_state_nxt;

    logic [CELLS-1:0] w_clear_mask;
    logic [1:0]       w_clear_cnt;
    logic [8:0]       w_score_sum;
    logic [7:0]       w_left_after;
    logic             w_paddle_live;

    hit_resolver u_hit_resolver (
        .i_ball_row   (ball_row),
        .i_ball_col   (ball_col),
        .i_ball_dir   (ball_dir),
        .i_bricks     (r_bricks),
        .o_clear_mask (w_clear_mask),
        .o_clear_cnt  (w_clear_cnt)
    );

    assign w_score_sum  = {1'b0, r_score} + {7'd0, w_clear_cnt};
    assign w_left_after = r_bricks_left - {6'd0, w_clear_cnt};
    assign w_paddle_live = (r_state == ST_IDLE) || (r_state == ST_PLAY) || (r_state == ST_SERVE);

    // Next-state and next-output decode for the game sequencer, map and paddle.
    always_comb begin
        w_state_nxt       = r_state;
        w_bricks_nxt      = r_bricks;
        w_paddle_pos_nxt  = r_paddle_pos;
        w_score_nxt       = r_score;
        w_bricks_left_nxt = r_bricks_left;
        w_lives_nxt       = r_lives;
        w_game_state_nxt  = GS_IDLE;

        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_PLAY;
            end
            ST_PLAY: begin
                if (ball_row == PADDLE_ROW) begin
                    // A miss pre-empts any clear pending on the same edge.
                    w_lives_nxt = r_lives - 2'd1;
                    w_state_nxt = (r_lives == 2'd1) ? ST_LOSE : ST_SERVE;
                end else begin
                    w_bricks_nxt      = r_bricks & ~w_clear_mask;
                    w_score_nxt       = w_score_sum[8] ? 8'hFF : w_score_sum[7:0];
                    w_bricks_left_nxt = w_left_after;
                    if (w_left_after == 8'd0) w_state_nxt = ST_WIN;
                end
            end
            ST_SERVE: begin
                // Single low cycle on ball_rst_n lets the stepper respawn.
                w_state_nxt = ST_PLAY;
            end
            ST_WIN, ST_LOSE: begin
                if (start) w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // IDLE keeps the field freshly loaded, including the edge that enters it.
        if (r_state == ST_IDLE || w_state_nxt == ST_IDLE) begin
            w_bricks_nxt      = BRICK_INIT;
            w_score_nxt       = 8'd0;
            w_lives_nxt       = LIVES_INIT;
            w_bricks_left_nxt = BRICKS_INIT;
        end

        // Paddle moves one column per edge; simultaneous requests cancel.
        if (w_paddle_live) begin
            if (paddle_inc && !paddle_dec && r_paddle_pos < PAD_MAX) begin
                w_paddle_pos_nxt = r_paddle_pos + 4'd1;
            end else if (paddle_dec && !paddle_inc && r_paddle_pos != 4'd0) begin
                w_paddle_pos_nxt = r_paddle_pos - 4'd1;
            end
        end

        case (w_state_nxt)
            ST_PLAY, ST_SERVE: w_game_state_nxt = GS_PLAY;
            ST_WIN:            w_game_state_nxt = GS_WIN;
            ST_LOSE:           w_game_state_nxt = GS_LOSE;
            default:           w_game_state_nxt = GS_IDLE;
        endcase

        w_ball_rst_n_nxt = (w_state_nxt == ST_PLAY);
        w_data_nxt       = w_bricks_nxt | paddle_mask(w_paddle_pos_nxt, PADDLE_W);
    end

    // State and registered outputs; reset restores the freshly loaded field at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_bricks      <= BRICK_INIT;
            r_paddle_pos  <= PAD_INIT;
            r_score       <= 8'd0;
            r_bricks_left <= BRICKS_INIT;
            r_lives       <= LIVES_INIT;
            r_ball_rst_n  <= 1'b0;
            r_data        <= DATA_INIT;
            r_game_state  <= GS_IDLE;
        end else begin
            r_state       <= w_state_nxt;
            r_bricks      <= w_bricks_nxt;
            r_paddle_pos  <= w_paddle_pos_nxt;
            r_score       <= w_score_nxt;
            r_bricks_left <= w_bricks_left_nxt;
            r_lives       <= w_lives_nxt;
            r_ball_rst_n  <= w_ball_rst_n_nxt;
            r_data        <= w_data_nxt;
            r_game_state  <= w_game_state_nxt;
        end
    end

    assign data        = r_data;
    assign ball_rst_n  = r_ball_rst_n;
    assign score       = r_score;
    assign bricks_left = r_bricks_left;
    assign lives       = r_lives;
    assign game_state  = r_game_state;

endmodule

// File: tb/tb_brick_field_ctrl.sv
// Directed bench for brick_field_ctrl with an expectation scoreboard.
// Latency: expectations are checked 1 time unit after the edge that produces them.
// Backpressure: n/a.
module tb_brick_field_ctrl;

    localparam logic [1:0] D_UR = 2'b00;
    localparam logic [1:0] D_UL = 2'b01;
    localparam logic [1:0] D_DL = 2'b11;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic         paddle_inc;
    logic         paddle_dec;
    logic [3:0]   ball_row;
    logic [3:0]   ball_col;
    logic [1:0]   ball_dir;
    logic [191:0] data;
    logic         ball_rst_n;
    logic [7:0]   score;
    logic [7:0]   bricks_left;
    logic [1:0]   lives;
    logic [1:0]   game_state;

    brick_field_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .paddle_inc  (paddle_inc),
        .paddle_dec  (paddle_dec),
        .ball_row    (ball_row),
        .ball_col    (ball_col),
        .ball_dir    (ball_dir),
        .data        (data),
        .ball_rst_n  (ball_rst_n),
        .score       (score),
        .bricks_left (bricks_left),
        .lives       (lives),
        .game_state  (game_state)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0]   gs;
        logic         rstn;
        logic [7:0]   score;
        logic [7:0]   left;
        logic [1:0]   lives;
        logic [191:0] data;
    } exp_t;

    exp_t         sb[$];
    int           n_tests = 0;
    int           n_fail  = 0;

    // Expected game picture, updated explicitly by each directed step.
    logic [191:0] m_map;
    int           m_pos;
    int           m_score;
    int           m_left;
    int           m_lives;
    int           m_gs;
    logic         m_rstn;

    // Rows 1..3 full: bits 16..63.
    function automatic logic [191:0] full_map();
        logic [191:0] m;
        m = {128'd0, 48'hFFFF_FFFF_FFFF, 16'd0};
        return m;
    endfunction

    function automatic logic [191:0] pad(input int pos);
        logic [191:0] m;
        m = '0;
        for (int c = pos; c < pos + 4; c++) m[176 + c] = 1'b1;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.gs    = 2'(m_gs);
        e.rstn  = m_rstn;
        e.score = 8'(m_score);
        e.left  = 8'(m_left);
        e.lives = 2'(m_lives);
        e.data  = m_map | pad(m_pos);
        sb.push_back(e);
    endtask

    task automatic compare(input string tag);
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("%s.game_state", tag),  {190'd0, game_state}, {190'd0, e.gs});
        chk($sformatf("%s.ball_rst_n", tag),  {191'd0, ball_rst_n}, {191'd0, e.rstn});
        chk($sformatf("%s.score", tag),       {184'd0, score},      {184'd0, e.score});
        chk($sformatf("%s.bricks_left", tag), {184'd0, bricks_left},{184'd0, e.left});
        chk($sformatf("%s.lives", tag),       {190'd0, lives},      {190'd0, e.lives});
        chk($sformatf("%s.data", tag),        data,                 e.data);
    endtask

    task automatic tick(input string tag);
        push_exp();
        @(posedge clock);
        #1;
        compare(tag);
    endtask

    task automatic check_now(input string tag);
        push_exp();
        compare(tag);
    endtask

    task automatic ball(input int r, input int c, input logic [1:0] d);
        ball_row = 4'(r);
        ball_col = 4'(c);
        ball_dir = d;
    endtask

    task automatic park();
        ball(6, 8, D_UR);
    endtask

    task automatic reload_model();
        m_map   = full_map();
        m_score = 0;
        m_left  = 48;
        m_lives = 3;
    endtask

    // Ball directly under a brick heading up-right: only that brick is struck.
    task automatic clear1(input int r, input int c);
        ball(r + 1, c, D_UR);
        m_map[r*16 + c] = 1'b0;
        m_score++;
        m_left--;
        if (m_left == 0) begin
            m_gs   = 2;
            m_rstn = 1'b0;
        end
        tick($sformatf("sweep_r%0d_c%0d", r, c));
    endtask

    task automatic sweep(input bit keep_last);
        for (int r = 3; r >= 1; r--) begin
            for (int c = 0; c < 16; c++) begin
                if (m_map[r*16 + c] && !(keep_last && r == 1 && c == 15)) clear1(r, c);
            end
        end
        park();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; start = 1'b0; paddle_inc = 1'b0; paddle_dec = 1'b0;
        park();
        reload_model();
        m_pos = 6; m_gs = 0; m_rstn = 1'b0;

        #12;
        check_now("reset");
        @(negedge clock);
        reset = 1'b1;
        tick("idle_hold");

        start = 1'b1; m_gs = 1; m_rstn = 1'b1;
        tick("start");
        start = 1'b0;

        // Vertical and horizontal neighbours both set: both go, diagonal stays.
        ball(3, 5, D_UR);
        m_map[2*16+5] = 1'b0; m_map[3*16+4] = 1'b0; m_score += 2; m_left -= 2;
        tick("hit_vh");
        // Only the diagonal set.
        ball(4, 4, D_UL);
        m_map[3*16+5] = 1'b0; m_score++; m_left--;
        tick("hit_diag");
        ball(4, 5, D_UR);
        tick("no_hit");
        ball(4, 0, D_UR);
        m_map[3*16+0] = 1'b0; m_score++; m_left--;
        tick("col0_v");
        ball(4, 0, D_UR);
        tick("col0_nowrap");
        ball(4, 15, D_UL);
        m_map[3*16+15] = 1'b0; m_score++; m_left--;
        tick("col15_v");
        ball(0, 7, D_DL);
        m_map[1*16+7] = 1'b0; m_score++; m_left--;
        tick("down_v");
        ball(0, 7, D_UR);
        tick("row0_up");
        ball(10, 7, D_DL);
        tick("paddle_safe");
        park();

        paddle_dec = 1'b1; m_pos = 5;
        tick("pad_dec");
        paddle_inc = 1'b1;
        tick("pad_both");
        paddle_dec = 1'b0; m_pos = 6;
        tick("pad_inc");
        paddle_inc = 1'b0;

        // Miss with lives to spare: one low cycle on ball_rst_n.
        ball(11, 7, D_UR); m_lives = 2; m_rstn = 1'b0;
        tick("miss1");
        m_rstn = 1'b1;
        tick("serve1");
        ball(11, 3, D_DL); m_lives = 1; m_rstn = 1'b0;
        tick("miss2");
        park(); m_rstn = 1'b1;
        tick("serve2");

        sweep(1'b1);

        // Last life lost while one brick remains: no clear, score holds.
        ball(11, 9, D_UL); m_lives = 0; m_gs = 3; m_rstn = 1'b0;
        tick("lose");
        ball(2, 15, D_UR); paddle_inc = 1'b1;
        tick("lose_hold");
        tick("lose_hold2");
        paddle_inc = 1'b0; park();

        start = 1'b1; reload_model(); m_gs = 0;
        tick("restart_idle");
        start = 1'b0;

        paddle_inc = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (m_pos < 12) m_pos++;
            tick("pad_sat_hi");
        end
        paddle_inc = 1'b0; paddle_dec = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (m_pos > 0) m_pos--;
            tick("pad_sat_lo");
        end
        paddle_dec = 1'b0; paddle_inc = 1'b1;
        for (int i = 0; i < 6; i++) begin
            m_pos++;
            tick("pad_back");
        end
        paddle_inc = 1'b0;

        start = 1'b1; m_gs = 1; m_rstn = 1'b1;
        tick("start2");
        start = 1'b0;
        sweep(1'b0);

        paddle_inc = 1'b1;
        tick("win_hold");
        paddle_inc = 1'b0;
        start = 1'b1; reload_model(); m_gs = 0;
        tick("win_restart");

        m_gs = 1; m_rstn = 1'b1;
        tick("start3");
        start = 1'b0;
        ball(2, 0, D_UR);
        m_map[1*16+0] = 1'b0; m_score++; m_left--;
        tick("pre_reset_hit");
        park(); paddle_inc = 1'b1; m_pos = 7;
        tick("pre_reset_pad");
        paddle_inc = 1'b0;

        #3;
        reset = 1'b0;
        #1;
        reload_model(); m_pos = 6; m_gs = 0; m_rstn = 1'b0;
        check_now("mid_reset");
        @(negedge clock);
        reset = 1'b1;
        tick("post_reset_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
